// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and length-field width.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd4,
`endif
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Gathers accepted stream bytes into little-endian 32-bit words; the first byte lands in [7:0].
// Pulses o_word_valid combinationally on the byte that completes a word.
module imem_word_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_take,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_lane;
  logic [23:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_lane <= 2'd0;
    end else if (i_take) begin
      r_lane <= r_lane + 2'd1;
    end
  end

  // Shift right so earlier bytes migrate toward the low lanes
  always_ff @(posedge i_clk) begin
    if (i_take) begin
      r_sr <= {i_byte, r_sr[23:8]};
    end
  end

  assign o_word_valid = i_take && (r_lane == 2'd3);
  assign o_word       = {i_byte, r_sr};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction memory and holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte_data,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_lo;
  logic [ADDR_W:0]     r_nwords;
  logic [ADDR_W:0]     r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif

  logic                w_ready;
  logic                w_take;
  logic                w_start;
  logic                w_data_full;
  logic                w_word_valid;
  logic [31:0]         w_word;
  logic [LEN_W-1:0]    w_len;

  assign w_data_full = (r_idx == r_nwords);
  assign w_len       = {i_byte_data, r_len_lo};
  assign w_start     = i_start &&
                       (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERR);

  // DATA drops ready once every word is in, covering the final write cycle
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI: w_ready = 1'b1;
      ST_DATA:              w_ready = !w_data_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK:               w_ready = 1'b1;
`endif
      default:              w_ready = 1'b0;
    endcase
  end

  assign w_take = i_byte_valid && w_ready;

  imem_word_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (w_start),
    .i_take       (w_take && (r_state == ST_DATA)),
    .i_byte       (i_byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = ST_LEN_LO;
    end else begin
      case (r_state)
        ST_LEN_LO: if (w_take) w_next = ST_LEN_HI;
        ST_LEN_HI: begin
          if (w_take) begin
            if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              w_next = ST_CHK;
`else
              w_next = ST_RUN;
`endif
            end else if ({1'b0, w_len} > DEPTH_L) begin
              w_next = ST_ERR;
            end else begin
              w_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_word_valid && ((r_idx + IDX_ONE) == r_nwords)) w_next = ST_CHK;
`else
          if (w_data_full) w_next = ST_RUN;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: if (w_take) w_next = (i_byte_data == r_sum) ? ST_RUN : ST_ERR;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_nwords <= '0;
      r_len_lo <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= w_word_valid;
      if (w_start) begin
        r_idx <= '0;
      end
      if (w_take && r_state == ST_LEN_LO) begin
        r_len_lo <= i_byte_data;
      end
      if (w_take && r_state == ST_LEN_HI) begin
        r_nwords <= w_len[ADDR_W:0];
      end
      if (w_word_valid) begin
        r_addr  <= r_idx[ADDR_W-1:0];
        r_wdata <= w_word;
        r_idx   <= r_idx + IDX_ONE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Running sum covers length and data bytes, never the checksum byte itself
      if (w_start) begin
        r_sum <= '0;
      end else if (w_take && r_state != ST_CHK) begin
        r_sum <= r_sum + i_byte_data;
      end
`endif
    end
  end

  assign o_byte_ready = w_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_done       = (r_state == ST_RUN);
  assign o_error      = (r_state == ST_ERR);
  assign o_cpu_rst    = (r_state != ST_RUN);
  assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_RUN) && (r_state != ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads against a byte-image model.
// Works in both the default build and with IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst, busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_we_cyc, start_cyc, done_cyc;
  bit tmo;
  logic [31:0] words[$];
  int          wr_a[$];
  logic [31:0] wr_d[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_byte_data  (byte_data),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_a.push_back(int'(imem_addr));
      wr_d.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) tmo = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Builds the byte image for words[0..n-1] and streams it; waits for done/error.
  task automatic load(input int n, input int stall_after, input int stall_len,
                      input bit rnd, input bit noise, input int chk_delta);
    logic [7:0] q[$];
    logic [7:0] sum;
    int t;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) q.push_back(words[i][8*k +: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum = 8'h00;
    foreach (q[i]) sum = sum + q[i];
    q.push_back(sum + 8'(chk_delta));
`else
    sum = 8'(chk_delta);
`endif
    wr_a.delete();
    wr_d.delete();
    tmo = 1'b0;
    pulse_start();
    start_cyc = cyc;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i + 1 == stall_after) repeat (stall_len) @(negedge clk);
      if (rnd && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (noise && i == 3) pulse_start();
    end
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) tmo = 1'b1;
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({cpu_rst, byte_ready, done, error, imem_we, busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl got cpu_rst/ready/done/err/we/busy=%b want 100000",
               {cpu_rst, byte_ready, done, error, imem_we, busy});
    end
    n_tests++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%0h wdata=%h want 0/0", imem_addr, imem_wdata);
    end
    byte_data  = 8'hA5;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    n_tests++;
    if (byte_ready !== 1'b0 || busy !== 1'b0 || wr_a.size() != 0) begin
      n_fail++;
      $display("FAIL idle_ignore got ready=%b busy=%b writes=%0d want 0 0 0",
               byte_ready, busy, wr_a.size());
    end
  endtask

  task automatic test_basic();
    words = '{32'h00000513, 32'h00100593};
    load(2, 0, 0, 1'b0, 1'b0, 0);
    n_tests++;
    if (tmo || wr_a.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count got writes=%0d tmo=%0b want 2", wr_a.size(), tmo);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (wr_a[i] != i || wr_d[i] !== words[i]) begin
          n_fail++;
          $display("FAIL basic_word%0d got %0d:%h want %0d:%h", i, wr_a[i], wr_d[i], i, words[i]);
        end
      end
    end
    n_tests++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status got done=%b cpu_rst=%b busy=%b err=%b want 1 0 0 0",
               done, cpu_rst, busy, error);
    end
    n_tests++;
    if (done_cyc != last_we_cyc + 1 || done_cyc - start_cyc != 11) begin
      n_fail++;
      $display("FAIL basic_timing got done@%0d lastwe@%0d lat=%0d want lastwe+1 lat=11",
               done_cyc, last_we_cyc, done_cyc - start_cyc);
    end
    pulse_start();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear got done=%b busy=%b cpu_rst=%b want 0 1 1", done, busy, cpu_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    wr_a.delete();
    tmo = 1'b0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (3) @(negedge clk);
    n_tests++;
    if (tmo || error !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0 || wr_a.size() != 0) begin
      n_fail++;
      $display("FAIL overflow got err=%b cpu_rst=%b ready=%b done=%b busy=%b writes=%0d want 1 1 0 0 0 0",
               error, cpu_rst, byte_ready, done, busy, wr_a.size());
    end
  endtask

  task automatic test_stall();
    words = '{32'h00000513, 32'h00100593};
    load(2, 6, 3, 1'b0, 1'b0, 0);
    n_tests++;
    if (tmo || wr_a.size() != 2 || wr_a[0] != 0 || wr_a[1] != 1 ||
        wr_d[0] !== words[0] || wr_d[1] !== words[1]) begin
      n_fail++;
      $display("FAIL stall_writes got n=%0d tmo=%0b want 2 writes 513/100593", wr_a.size(), tmo);
    end
    n_tests++;
    if (done !== 1'b1 || done_cyc - start_cyc != 14) begin
      n_fail++;
      $display("FAIL stall_timing got done=%b lat=%0d want 1 lat=14", done, done_cyc - start_cyc);
    end
  endtask

  task automatic test_rst_mid();
    wr_a.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h00);
    byte_data  = 8'h00;
    byte_valid = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wr_a.size() != 0 || byte_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got writes=%0d ready=%b busy=%b cpu_rst=%b done=%b want 0 0 0 1 0",
               wr_a.size(), byte_ready, busy, cpu_rst, done);
    end
    words = '{32'hDEADBEEF, 32'h01234567};
    load(2, 0, 0, 1'b0, 1'b0, 0);
    n_tests++;
    if (tmo || done !== 1'b1 || wr_a.size() != 2 || wr_d[0] !== words[0] || wr_d[1] !== words[1]) begin
      n_fail++;
      $display("FAIL rst_reload got done=%b writes=%0d want 1 2", done, wr_a.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(0, 7);
      int bad = 0;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load(n, 0, 0, 1'b1, 1'b1, 0);
      for (int i = 0; i < n && i < wr_a.size(); i++)
        if (wr_a[i] != i || wr_d[i] !== words[i]) bad++;
      n_tests++;
      if (tmo || wr_a.size() != n || bad != 0 || done !== 1'b1 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d n=%0d got writes=%0d bad=%0d done=%b err=%b want %0d 0 1 0",
                 it, n, wr_a.size(), bad, done, error, n);
      end
    end
  endtask

  task automatic test_full();
    int bad = 0;
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    load(DEPTH, 0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < DEPTH && i < wr_a.size(); i++)
      if (wr_a[i] != i || wr_d[i] !== words[i]) bad++;
    n_tests++;
    if (tmo || wr_a.size() != DEPTH || bad != 0 || wr_a[wr_a.size()-1] != DEPTH - 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_depth got writes=%0d bad=%0d done=%b want %0d 0 1", wr_a.size(), bad, done, DEPTH);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words = '{32'h00000513};
    load(1, 0, 0, 1'b0, 1'b0, 0);
    n_tests++;
    if (tmo || done !== 1'b1 || error !== 1'b0 || wr_a.size() != 1 || wr_d[0] !== 32'h00000513 ||
        done_cyc != last_we_cyc + 1) begin
      n_fail++;
      $display("FAIL chk_good got done=%b err=%b writes=%0d want 1 0 1", done, error, wr_a.size());
    end
    load(1, 0, 0, 1'b0, 1'b0, -1);
    n_tests++;
    if (tmo || error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || wr_a.size() != 1 ||
        wr_d[0] !== 32'h00000513) begin
      n_fail++;
      $display("FAIL chk_bad got err=%b done=%b cpu_rst=%b writes=%0d want 1 0 1 1",
               error, done, cpu_rst, wr_a.size());
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_rst_mid();
    test_random();
    test_full();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
